lfsr_checker: RTL and testbench



---
 rtl/lfsr_checker.sv | 134 +++++++++++++
 tb/tb_lfsr_checker.sv | 269 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/lfsr_checker.sv
// Receive-side checker for the 16-bit Fibonacci LFSR pattern: self-synchronises a local LFSR and counts bad words.
// Optional feature macro LFSR_CHECKER_STUCK_EN adds stuck_o (most recent valid word was all-zero).
module lfsr_checker #(
    parameter int unsigned      WIDTH        = 16,
    parameter logic [WIDTH-1:0] TAPS         = 16'hB400,
    parameter int unsigned      LOCK_COUNT   = 4,
    parameter int unsigned      UNLOCK_COUNT = 4,
    parameter int unsigned      ERR_W        = 16
) (
    input  logic             clk_i,
    input  logic             reset_i,
    input  logic [WIDTH-1:0] data_i,
    input  logic             valid_i,
    input  logic             clear_i,
    output logic             locked_o,
    output logic             error_o,
`ifdef LFSR_CHECKER_STUCK_EN
    output logic             stuck_o,
`endif
    output logic [ERR_W-1:0] err_count_o
);

    localparam int unsigned MAX_CNT = (LOCK_COUNT > UNLOCK_COUNT) ? LOCK_COUNT : UNLOCK_COUNT;
    localparam int unsigned RUN_W   = ($clog2(MAX_CNT + 1) > 3) ? $clog2(MAX_CNT + 1) : 3;

    typedef enum logic [1:0] {HUNT, SYNC, LOCKED} state_e;

    function automatic logic [WIDTH-1:0] lfsr_next(input logic [WIDTH-1:0] s);
        return {s[WIDTH-2:0], ^(s & TAPS)};
    endfunction

    function automatic logic [ERR_W-1:0] sat_inc(input logic [ERR_W-1:0] c);
        return (&c) ? c : c + ERR_W'(1);
    endfunction

    state_e             state_q, state_d;
    logic [WIDTH-1:0]   ref_q, ref_d;
    logic [RUN_W-1:0]   run_q, run_d;
    logic [ERR_W-1:0]   err_q, err_d;
    logic               error_q, error_d;
    logic               locked_q, locked_d;
    logic [WIDTH-1:0]   pred;
    logic [RUN_W-1:0]   run_inc;

    assign pred    = lfsr_next(ref_q);
    assign run_inc = run_q + RUN_W'(1);

    always_comb begin
        state_d = state_q;
        ref_d   = ref_q;
        run_d   = run_q;
        error_d = 1'b0;
        if (valid_i) begin
            unique case (state_q)
                HUNT: begin
                    // The all-zero word is the LFSR lockup value and can never seed a valid stream.
                    if (data_i != '0) begin
                        ref_d   = data_i;
                        run_d   = '0;
                        state_d = SYNC;
                    end
                end
                SYNC: begin
                    ref_d = data_i;
                    if (data_i == pred) begin
                        if (run_inc == RUN_W'(LOCK_COUNT)) begin
                            run_d   = '0;
                            state_d = LOCKED;
                        end else begin
                            run_d = run_inc;
                        end
                    end else begin
                        run_d = '0;
                        if (data_i == '0) state_d = HUNT;
                    end
                end
                LOCKED: begin
                    // Free-running once locked so a single corrupted word costs exactly one error.
                    ref_d = pred;
                    if (data_i != pred) begin
                        error_d = 1'b1;
                        if (run_inc == RUN_W'(UNLOCK_COUNT)) begin
                            run_d   = '0;
                            state_d = HUNT;
                        end else begin
                            run_d = run_inc;
                        end
                    end else begin
                        run_d = '0;
                    end
                end
                default: state_d = HUNT;
            endcase
        end
        locked_d = (state_d == LOCKED);
        if (clear_i)      err_d = '0;
        else if (error_d) err_d = sat_inc(err_q);
        else              err_d = err_q;
    end

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            state_q  <= HUNT;
            ref_q    <= '0;
            run_q    <= '0;
            err_q    <= '0;
            error_q  <= 1'b0;
            locked_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            ref_q    <= ref_d;
            run_q    <= run_d;
            err_q    <= err_d;
            error_q  <= error_d;
            locked_q <= locked_d;
        end
    end

    assign locked_o    = locked_q;
    assign error_o     = error_q;
    assign err_count_o = err_q;

`ifdef LFSR_CHECKER_STUCK_EN
    logic stuck_q;

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i)      stuck_q <= 1'b0;
        else if (valid_i) stuck_q <= (data_i == '0);
    end

    assign stuck_o = stuck_q;
`endif

endmodule

// File: tb/tb_lfsr_checker.sv
// Randomised bench for lfsr_checker: default instance plus an ERR_W=4 instance for saturation, against a word-level model.
module tb_lfsr_checker;

    localparam logic [15:0] TAPS     = 16'hB400;
    localparam int          LOCK_N   = 4;
    localparam int          UNLOCK_N = 4;

    logic        clk = 1'b0;
    logic        reset_i = 1'b1;
    logic [15:0] data_i = '0;
    logic        valid_i = 1'b0;
    logic        clear_i = 1'b0;
    logic        locked_o, error_o, locked4, error4;
    logic [15:0] err16;
    logic [3:0]  err4;
`ifdef LFSR_CHECKER_STUCK_EN
    logic        stuck_o, stuck4;
`endif

    always #5 clk = ~clk;

    lfsr_checker dut (
        .clk_i(clk), .reset_i(reset_i), .data_i(data_i), .valid_i(valid_i), .clear_i(clear_i),
        .locked_o(locked_o), .error_o(error_o),
`ifdef LFSR_CHECKER_STUCK_EN
        .stuck_o(stuck_o),
`endif
        .err_count_o(err16)
    );

    lfsr_checker #(.ERR_W(4)) dut4 (
        .clk_i(clk), .reset_i(reset_i), .data_i(data_i), .valid_i(valid_i), .clear_i(clear_i),
        .locked_o(locked4), .error_o(error4),
`ifdef LFSR_CHECKER_STUCK_EN
        .stuck_o(stuck4),
`endif
        .err_count_o(err4)
    );

    int checks = 0;
    int errors = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [15:0] nxt(input logic [15:0] s);
        return {s[14:0], ^(s & TAPS)};
    endfunction

    function automatic logic [15:0] bad_mask();
        logic [15:0] m;
        m = 16'($urandom);
        if (m == '0) m = 16'h0001;
        return m;
    endfunction

    // Word-level model: mode 0 = hunting, 1 = syncing, 2 = locked.
    int          m_mode, m_run, m_err16, m_err4;
    logic [15:0] m_last;
    bit          m_error, m_stuck;

    task automatic model_reset();
        m_mode = 0; m_run = 0; m_err16 = 0; m_err4 = 0;
        m_last = '0; m_error = 0; m_stuck = 0;
    endtask

    task automatic model_step(input bit v, input logic [15:0] d, input bit c);
        logic [15:0] pred;
        m_error = 0;
        if (v) begin
            pred    = nxt(m_last);
            m_stuck = (d == 16'h0000);
            if (m_mode == 0) begin
                if (d != 0) begin m_last = d; m_run = 0; m_mode = 1; end
            end else if (m_mode == 1) begin
                if (d == pred) begin
                    m_last = d; m_run++;
                    if (m_run == LOCK_N) begin m_mode = 2; m_run = 0; end
                end else begin
                    m_last = d; m_run = 0;
                    if (d == 0) m_mode = 0;
                end
            end else begin
                m_last = pred;
                if (d != pred) begin
                    m_error = 1; m_run++;
                    if (m_run == UNLOCK_N) begin m_mode = 0; m_run = 0; end
                end else begin
                    m_run = 0;
                end
            end
        end
        if (c) begin
            m_err16 = 0; m_err4 = 0;
        end else if (m_error) begin
            if (m_err16 < 65535) m_err16++;
            if (m_err4 < 15) m_err4++;
        end
    endtask

    task automatic check_outputs();
        check("locked", 32'(locked_o), 32'(m_mode == 2));
        check("error", 32'(error_o), 32'(m_error));
        check("count16", 32'(err16), 32'(m_err16));
        check("locked4", 32'(locked4), 32'(m_mode == 2));
        check("error4", 32'(error4), 32'(m_error));
        check("count4", 32'(err4), 32'(m_err4));
`ifdef LFSR_CHECKER_STUCK_EN
        check("stuck", 32'(stuck_o), 32'(m_stuck));
        check("stuck4", 32'(stuck4), 32'(m_stuck));
`endif
    endtask

    task automatic step(input bit v, input logic [15:0] d, input bit c);
        valid_i = v; data_i = d; clear_i = c;
        @(posedge clk);
        model_step(v, d, c);
        #1;
        check_outputs();
    endtask

    logic [15:0] g;

    task automatic send_good(input int n);
        for (int i = 0; i < n; i++) begin
            g = nxt(g);
            step(1'b1, g, 1'b0);
        end
    endtask

    task automatic send_bad(input int n);
        for (int i = 0; i < n; i++) begin
            g = nxt(g);
            step(1'b1, g ^ bad_mask(), 1'b0);
        end
    endtask

    task automatic seed_and_lock();
        g = 16'($urandom) | 16'h0001;
        step(1'b1, g, 1'b0);
        send_good(LOCK_N);
    endtask

    task automatic do_reset();
        reset_i = 1'b1;
        #2;
        model_reset();
        @(posedge clk);
        #1;
        reset_i = 1'b0;
        check_outputs();
    endtask

    initial begin
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        check_outputs();
        reset_i = 1'b0;

        // Directed lock from 0x0001
        g = 16'h0001;
        step(1'b1, g, 1'b0);
        send_good(3);
        check("not_yet_locked", 32'(locked_o), 32'd0);
        send_good(1);
        check("lock_after_5", 32'(locked_o), 32'd1);
        check("lock_count0", 32'(err16), 32'd0);
        while (g != 16'h0400) send_good(1);
        step(1'b1, 16'h0801, 1'b0);
        g = 16'h0801;
        check("word_0801_ok", 32'(error_o), 32'd0);

        // Single error
        g = nxt(g);
        step(1'b1, g ^ 16'h0001, 1'b0);
        check("single_pulse", 32'(error_o), 32'd1);
        send_good(5);
        check("single_count", 32'(err16), 32'd1);
        check("single_locked", 32'(locked_o), 32'd1);

        // Unlock and relock
        send_bad(3);
        check("still_locked_3bad", 32'(locked_o), 32'd1);
        send_bad(1);
        check("unlock_4bad", 32'(locked_o), 32'd0);
        check("unlock_count", 32'(err16), 32'd5);
        seed_and_lock();
        check("relock", 32'(locked_o), 32'd1);

        // Gap then continue
        for (int i = 0; i < 10; i++) step(1'b0, 16'($urandom), 1'b0);
        send_good(3);
        check("gap_locked", 32'(locked_o), 32'd1);

        // Zero words in HUNT
        send_bad(4);
        for (int i = 0; i < 3; i++) step(1'b1, 16'h0000, 1'b0);
        check("zero_hunt", 32'(locked_o), 32'd0);
        seed_and_lock();

        // Saturation of the 4-bit counter, then clear against a bad word
        for (int i = 0; i < 20; i++) begin
            send_bad(1);
            send_good(1);
        end
        check("sat4", 32'(err4), 32'd15);
        g = nxt(g);
        step(1'b1, g ^ 16'h0001, 1'b1);
        check("clear_pulse", 32'(error_o), 32'd1);
        check("clear_count", 32'(err16), 32'd0);

        // Random traffic
        for (int i = 0; i < 3000; i++) begin
            int r;
            bit c;
            r = int'($urandom % 100);
            c = ($urandom % 64) == 0;
            if (r < 15) begin
                step(1'b0, 16'($urandom), c);
            end else if (r < 22) begin
                g = nxt(g);
                step(1'b1, g ^ bad_mask(), c);
            end else if (r < 24) begin
                g = 16'($urandom) | 16'h0001;
                step(1'b1, g, c);
            end else if (r < 25) begin
                step(1'b1, 16'h0000, c);
            end else begin
                g = nxt(g);
                step(1'b1, g, c);
            end
        end

        // Asynchronous reset while locked with count 3
        do_reset();
        seed_and_lock();
        for (int i = 0; i < 3; i++) begin
            send_bad(1);
            send_good(1);
        end
        check("pre_reset_count", 32'(err16), 32'd3);
        reset_i = 1'b1;
        #2;
        check("async_locked", 32'(locked_o), 32'd0);
        check("async_count", 32'(err16), 32'd0);
        check("async_error", 32'(error_o), 32'd0);
        model_reset();
        @(posedge clk);
        #1;
        reset_i = 1'b0;
        check_outputs();
        g = 16'($urandom) | 16'h0001;
        step(1'b1, g, 1'b0);
        send_good(LOCK_N - 1);
        check("relock_not_4", 32'(locked_o), 32'd0);
        send_good(1);
        check("relock_5", 32'(locked_o), 32'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
